// File: rtl/wb_block_reader_pkg.sv
// rtl/wb_block_reader_pkg.sv - shared types and constants for wb_block_reader
// Purpose: FSM state encoding, bus byte-lane and word-size constants.
// Ports: none (package).
package wb_block_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } rd_state_t;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/wb_block_reader_if.sv
// rtl/wb_block_reader_if.sv - Wishbone classic bus bundle (wshb_if)
// Purpose: groups the Wishbone master/slave signals of one bus segment.
// Ports: clk (input, shared bus clock).
//   master modport drives cyc,stb,we,sel,adr,dat_ms,cti,bte; receives dat_sm,ack,err,rty.
//   slave modport is the mirror image.
interface wshb_if (input logic clk);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;
  logic        err;
  logic        rty;
  logic [2:0]  cti;
  logic [1:0]  bte;

  modport master (
    input  clk, dat_sm, ack, err, rty,
    output cyc, stb, we, sel, adr, dat_ms, cti, bte
  );

  modport slave (
    input  clk, cyc, stb, we, sel, adr, dat_ms, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wb_block_reader_fifo.sv
// rtl/wb_block_reader_fifo.sv - show-ahead synchronous FIFO (sync_fifo)
// Purpose: word buffer between the bus side and the output stream.
// Ports: clk, rst (async, active-high); push/push_data write; pop read;
//   flush empties the FIFO; head is the oldest word (valid when !empty);
//   empty flag; count = words stored (0..DEPTH).
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != FULL_C);
  assign do_pop  = pop && (count != '0);
  assign empty   = (count == '0);
  assign head    = mem[rptr];

  // Storage needs no reset; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_block_reader.sv
// rtl/wb_block_reader.sv - Wishbone classic block reader feeding a valid/ready stream
// Purpose: on start, reads nwords consecutive words from base_adr, one access at a
//   time, and streams them out in address order through a show-ahead FIFO.
// Ports: clk, rst (async, active-high); start/base_adr/nwords request;
//   busy/done/error status; out_data/out_valid/out_ready stream;
//   wb_m Wishbone classic master.
module wb_block_reader
  import wb_block_reader_pkg::*;
#(
  parameter int LEN_W      = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [LEN_W-1:0] nwords,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  wshb_if.master           wb_m
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_ISSUE = 2'(ISSUE);
  localparam logic [1:0] S_GAP   = 2'(GAP);
  localparam logic [1:0] S_DRAIN = 2'(DRAIN);

  logic [1:0]       state;
  logic [29:0]      base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] idx_next;
  logic             done_q;
  logic             error_q;

  logic             push;
  logic             pop;
  logic             flush;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      idx_off;

  logic             unused_ok;
  assign unused_ok = &{1'b0, base_adr[1:0]};

  assign idx_next = idx + 1'b1;
  assign idx_off  = {{(30-LEN_W){1'b0}}, idx, 2'b00};

  // Read-only classic master: every access is a single full-word read.
  assign wb_m.cyc    = (state == S_ISSUE);
  assign wb_m.stb    = (state == S_ISSUE);
  assign wb_m.we     = 1'b0;
  assign wb_m.sel    = WB_SEL_ALL;
  assign wb_m.dat_ms = '0;
  assign wb_m.cti    = '0;
  assign wb_m.bte    = '0;
  assign wb_m.adr    = {base_q, 2'b00} + idx_off;

  // err wins over ack so a faulty cycle never deposits data.
  assign push  = (state == S_ISSUE) && wb_m.ack && !wb_m.err;
  assign flush = (state == S_ISSUE) && wb_m.err;
  assign pop   = out_valid && out_ready;

  assign out_valid = !fifo_empty;
  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign error     = error_q;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wb_m.dat_sm),
    .pop       (pop),
    .flush     (flush),
    .head      (out_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx     <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            error_q <= 1'b0;
            if (nwords != '0) begin
              base_q <= base_adr[31:2];
              len_q  <= nwords;
              idx    <= '0;
              state  <= S_ISSUE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (wb_m.err) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            state   <= S_IDLE;
          end else if (wb_m.ack) begin
            idx   <= idx_next;
            state <= (idx_next == len_q) ? S_DRAIN : S_GAP;
          end else if (wb_m.rty) begin
            state <= S_GAP;
          end
        end
        S_GAP: begin
          // Only reissue with a free slot, so the next ack can always be pushed.
          if (fifo_count < DEPTH_C) state <= S_ISSUE;
        end
        S_DRAIN: begin
          if ((fifo_count == '0) || ((fifo_count == ONE_C) && pop)) begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_block_reader.sv
// tb/tb_wb_block_reader.sv - bench for wb_block_reader with a BlockRAM slave model
module tb_wb_block_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_adr = '0;
  logic [11:0] nwords = '0;
  logic        busy, done, error;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [31:0] adr_log [$];
  int ack_cnt = 0;
  int cyc_cnt = 0;
  int acc_cnt = 0;
  int err_at = 0;
  int rty_at = 0;
  logic [31:0] mem [0:2047];

  always #5 clk = ~clk;

  wshb_if bus (.clk(clk));

  wb_block_reader #(.LEN_W(12), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_adr  (base_adr),
    .nwords    (nwords),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wb_m      (bus)
  );

  // BlockRAM slave: answers in the second cycle of a strobe; err/rty injected by access number.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ack    <= 1'b0;
      bus.err    <= 1'b0;
      bus.rty    <= 1'b0;
      bus.dat_sm <= '0;
    end else if (bus.cyc && bus.stb && !bus.ack && !bus.err && !bus.rty) begin
      acc_cnt <= acc_cnt + 1;
      if (acc_cnt + 1 == err_at)      bus.err <= 1'b1;
      else if (acc_cnt + 1 == rty_at) bus.rty <= 1'b1;
      else begin
        bus.ack    <= 1'b1;
        bus.dat_sm <= mem[bus.adr[12:2]];
      end
    end else begin
      bus.ack <= 1'b0;
      bus.err <= 1'b0;
      bus.rty <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: compares every accepted output word against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ack) ack_cnt++;
      if (bus.cyc) cyc_cnt++;
      if (bus.cyc && (bus.ack || bus.rty || bus.err)) adr_log.push_back(bus.adr);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got %0h expected none", out_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL stream_data: got %0h expected %0h", out_data, e);
          end
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] b, input logic [11:0] n);
    @(negedge clk);
    base_adr = b;
    nwords   = n;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    base_adr = 32'hFFFF_FFF0;
    nwords   = 12'hFFF;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    int base_cnt;
    int n;
    for (int i = 0; i < 2048; i++) mem[i] = i;

    // Reset state
    #12;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_error", {31'b0, error}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_cyc", {31'b0, bus.cyc}, 0);
    chk("rst_adr", bus.adr, 0);
    chk("rst_sel", {28'b0, bus.sel}, 32'hF);
    @(negedge clk);
    rst = 1'b0;

    // 1: four words, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    do_start(32'h0, 12'd4);
    chk("t1_busy", {31'b0, busy}, 1);
    wait_done("t1");
    chk("t1_all_popped", exp_q.size(), 0);
    chk("t1_error", {31'b0, error}, 0);
    chk("t1_busy_low", {31'b0, busy}, 0);
    @(negedge clk);
    chk("t1_done_pulse", {31'b0, done}, 0);

    // 2: back-pressure fills the FIFO, then releases
    out_ready = 1'b0;
    for (int i = 4; i < 24; i++) exp_q.push_back(i);
    base_cnt = ack_cnt;
    do_start(32'h10, 12'd20);
    repeat (100) @(negedge clk);
    chk("t2_acks_held", ack_cnt - base_cnt, 8);
    chk("t2_cyc_low", {31'b0, bus.cyc}, 0);
    chk("t2_head", out_data, 32'd4);
    out_ready = 1'b1;
    wait_done("t2");
    chk("t2_all_popped", exp_q.size(), 0);
    chk("t2_acks_total", ack_cnt - base_cnt, 20);

    // 3: empty transfer
    base_cnt = cyc_cnt;
    do_start(32'h80, 12'd0);
    chk("t3_done", {31'b0, done}, 1);
    chk("t3_busy", {31'b0, busy}, 0);
    @(negedge clk);
    chk("t3_done_pulse", {31'b0, done}, 0);
    chk("t3_no_cyc", cyc_cnt - base_cnt, 0);

    // 4: bus error on third access
    out_ready = 1'b0;
    err_at = acc_cnt + 3;
    do_start(32'h0, 12'd5);
    wait_done("t4");
    chk("t4_error", {31'b0, error}, 1);
    chk("t4_valid", {31'b0, out_valid}, 0);
    chk("t4_cyc", {31'b0, bus.cyc}, 0);
    chk("t4_busy", {31'b0, busy}, 0);
    err_at = 0;
    out_ready = 1'b1;
    exp_q.push_back(32'd0);
    do_start(32'h0, 12'd1);
    chk("t4_error_cleared", {31'b0, error}, 0);
    wait_done("t4b");
    chk("t4b_all_popped", exp_q.size(), 0);

    // 5: retry on second access
    adr_log.delete();
    rty_at = acc_cnt + 2;
    for (int i = 0; i < 3; i++) exp_q.push_back(i);
    do_start(32'h0, 12'd3);
    wait_done("t5");
    rty_at = 0;
    chk("t5_all_popped", exp_q.size(), 0);
    chk("t5_accesses", adr_log.size(), 4);
    if (adr_log.size() == 4) begin
      chk("t5_rty_adr", adr_log[1], 32'h4);
      chk("t5_reissue_adr", adr_log[2], 32'h4);
      chk("t5_last_adr", adr_log[3], 32'h8);
    end

    // 6: reset mid-transfer, then a fresh transfer
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    do_start(32'h0, 12'd8);
    n = 0;
    for (int i = 0; i < 200 && n < 2; i++) begin
      @(negedge clk);
      if (bus.ack) n++;
    end
    chk("t6_two_acks", n, 2);
    rst = 1'b1;
    #1;
    chk("t6_busy", {31'b0, busy}, 0);
    chk("t6_done", {31'b0, done}, 0);
    chk("t6_error", {31'b0, error}, 0);
    chk("t6_valid", {31'b0, out_valid}, 0);
    chk("t6_cyc", {31'b0, bus.cyc}, 0);
    chk("t6_adr", bus.adr, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'd16);
    exp_q.push_back(32'd17);
    do_start(32'h40, 12'd2);
    wait_done("t6");
    chk("t6_all_popped", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
